// File: rtl/pid_sample_sequencer.sv
// pid_sample_sequencer: periodic sample scheduler for the HLS PID core.
// Latches sensors on each tick, runs one ap_ctrl_hs launch, captures duties.
//
// Ports:
//   HCLK, HRESETn              clock, synchronous active-low reset
//   enable_i, period_i         run enable, sample period minus 1
//   din0_i, din1_i             sensor samples
//   ap_start_o, ap_ready_i,
//   ap_done_i                  PID core ap_ctrl_hs handshake
//   pid_din0_o, pid_din1_o     latched samples to the core
//   pid_dout0_i, pid_dout1_i   core results
//   duty0_o, duty1_o           captured duties
//   duty_valid_o               1-cycle strobe, duties updated
//   overrun_o, timeout_o       sticky fault flags
//   fault_clr_i                clears both fault flags
//   sample_cnt_o               completed samples, wraps
module pid_sample_sequencer #(
    parameter int DW       = 25,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [DW-1:0]       din0_i,
    input  logic [DW-1:0]       din1_i,
    output logic                ap_start_o,
    input  logic                ap_ready_i,
    input  logic                ap_done_i,
    output logic [DW-1:0]       pid_din0_o,
    output logic [DW-1:0]       pid_din1_o,
    input  logic [DW-1:0]       pid_dout0_i,
    input  logic [DW-1:0]       pid_dout1_i,
    output logic [DW-1:0]       duty0_o,
    output logic [DW-1:0]       duty1_o,
    output logic                duty_valid_o,
    output logic                overrun_o,
    output logic                timeout_o,
    input  logic                fault_clr_i,
    output logic [CNT_W-1:0]    sample_cnt_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LAUNCH,
        WAIT_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PERIOD_W-1:0] tick_cnt_q;
    logic [WD_W-1:0]     wd_q;
    logic                tick;
    logic                busy;
    logic                capture;
    logic                launch;
    logic                expire;
    logic                overrun_set;

    // >= rather than == so a lowered period takes effect at once.
    assign tick = enable_i && (tick_cnt_q >= period_i);
    assign busy = (state_q == LAUNCH) || (state_q == WAIT_DONE);

    assign ap_start_o = (state_q == LAUNCH);

    // A tick coinciding with the capturing done is a back-to-back
    // relaunch, not a dropped sample.
    assign overrun_set = tick && busy && !capture;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tick_cnt_q <= '0;
        end else if (!enable_i || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + PERIOD_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        launch  = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = ARMED;
            end
            ARMED: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = LAUNCH;
                    launch  = 1'b1;
                end
            end
            LAUNCH, WAIT_DONE: begin
                // In LAUNCH a done only counts alongside ready.
                if (ap_done_i && (ap_ready_i || state_q == WAIT_DONE)) begin
                    capture = 1'b1;
                    if (tick) begin
                        state_d = LAUNCH;
                        launch  = 1'b1;
                    end else if (enable_i) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_q == WD_LAST) begin
                    expire  = 1'b1;
                    state_d = ARMED;
                end else if (state_q == LAUNCH && ap_ready_i) begin
                    state_d = WAIT_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            pid_din0_o   <= '0;
            pid_din1_o   <= '0;
            duty0_o      <= '0;
            duty1_o      <= '0;
            duty_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
            sample_cnt_o <= '0;
        end else begin
            state_q      <= state_d;
            duty_valid_o <= capture;

            if (launch) begin
                wd_q <= '0;
            end else if (busy) begin
                wd_q <= wd_q + WD_W'(1);
            end else begin
                wd_q <= '0;
            end

            if (launch) begin
                pid_din0_o <= din0_i;
                pid_din1_o <= din1_i;
            end

            if (capture) begin
                duty0_o      <= pid_dout0_i;
                duty1_o      <= pid_dout1_i;
                sample_cnt_o <= sample_cnt_o + CNT_W'(1);
            end

            // Set events beat a simultaneous clear.
            if (overrun_set) begin
                overrun_o <= 1'b1;
            end else if (fault_clr_i) begin
                overrun_o <= 1'b0;
            end

            if (expire) begin
                timeout_o <= 1'b1;
            end else if (fault_clr_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pid_sample_sequencer.md
Name: pid_sample_sequencer

Overview:
- Periodic sample scheduler that drives the HLS PID_Controller ap_ctrl_hs handshake.
- Latches two sensor inputs on each sample tick and launches one PID computation.
- Captures the two duty outputs on ap_done, then raises a one-cycle valid strobe.
- Sits between the AHB PID wrapper's configuration registers, the PID core and the PWM/duty consumers; also reports overrun and timeout faults.

Parameters:
DW, 25, width of din/dout/duty data paths
PERIOD_W, 16, width of the sample period register
TIMEOUT, 1024, max HCLK cycles from launch to ap_done before abort
CNT_W, 16, width of the completed-sample counter

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, synchronous, active-low
enable_i  in  1  run enable
period_i  in  PERIOD_W  sample period minus 1, in HCLK cycles
din0_i, din1_i  in  DW  sensor samples
ap_start_o  out  1  PID core start
ap_ready_i  in  1  PID core accepted inputs
ap_done_i  in  1  PID core result valid (1-cycle pulse)
pid_din0_o, pid_din1_o  out  DW  latched samples to PID core
pid_dout0_i, pid_dout1_i  in  DW  PID core results
duty0_o, duty1_o  out  DW  captured duty values
duty_valid_o  out  1  1-cycle strobe, duty updated
overrun_o  out  1  sticky: tick dropped while busy
timeout_o  out  1  sticky: core failed to finish
fault_clr_i  in  1  clears overrun_o and timeout_o
sample_cnt_o  out  CNT_W  completed samples, wraps

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is synchronous and active-low, sampled on the HCLK rising edge.
- Reset values: all outputs 0, state IDLE, tick counter 0, watchdog 0. Reset mid-computation drops ap_start_o the next edge; any late ap_done_i is ignored (state IDLE).
- Tick counter:
  - Cleared while enable_i=0; otherwise increments each cycle.
  - When cnt >= period_i: tick asserts that cycle and cnt returns to 0.
  - Tick period is period_i+1 cycles; period_i=0 gives a tick every cycle.
  - A lowered period_i takes effect immediately through the >= compare.
- States:
  - IDLE: enable_i=1 -> ARMED.
  - ARMED: enable_i=0 -> IDLE. Tick -> LAUNCH; pid_din0/1_o <= din0/1_i at that edge.
  - LAUNCH: ap_start_o=1 (Moore).
    - ap_ready_i=1 and ap_done_i=1 in the same cycle -> capture, then ARMED (or IDLE if enable_i=0).
    - ap_ready_i=1 alone -> WAIT_DONE.
  - WAIT_DONE: ap_start_o=0. ap_done_i=1 -> capture, then ARMED (or IDLE if enable_i=0).
- Capture (on the ap_done_i edge):
  - duty0/1_o <= pid_dout0/1_i.
  - duty_valid_o=1 for the following cycle only.
  - sample_cnt_o +1, wrapping at 2^CNT_W.
- Back-to-back: tick in the same cycle as the capturing ap_done_i with enable_i=1 -> goes directly to LAUNCH, latches new din, no overrun.
- Overrun: tick while in LAUNCH or WAIT_DONE (other than the back-to-back case) -> tick dropped, overrun_o <= 1.
- Watchdog:
  - Counts cycles in LAUNCH/WAIT_DONE and clears on entry to LAUNCH.
  - On reaching TIMEOUT-1 without ap_done_i: timeout_o <= 1, ap_start_o <= 0, state -> ARMED.
  - No capture and no count increment for that sample.
- Enable drop mid-computation: the current computation completes and is captured (the HLS core cannot be aborted), then IDLE. No further ticks.
- fault_clr_i: clears both sticky flags. A set event in the same cycle wins over the clear.
- Latency:
  - Tick edge T -> ap_start_o high from T+1.
  - ap_done_i at D -> duty_o and duty_valid_o at D+1.
  - Per-sample overhead beyond core latency: 2 cycles.

Test Plan:
1. Reset, enable=1, period_i=9, core done 3 cycles after ready -> ticks every 10 cycles; ap_start_o high 1 cycle per tick; duty_valid_o 10 cycles apart; sample_cnt_o=5 after 5 ticks; overrun_o=0.
2. period_i=3, core latency 6 cycles -> second tick is dropped, overrun_o=1. fault_clr_i pulse -> overrun_o=0 unless an overrun recurs that same cycle.
3. ap_ready_i and ap_done_i asserted together with pid_dout0_i=25'h0ABCDE -> duty0_o=25'h0ABCDE one cycle later; state ARMED; no WAIT_DONE visit.
4. ap_done_i never asserted, TIMEOUT=16 -> timeout_o=1 exactly 16 cycles after launch; ap_start_o=0; next tick relaunches normally.
5. enable_i deasserted during WAIT_DONE -> capture still occurs with duty_valid_o=1; then IDLE; no ap_start_o for 3*(period_i+1) cycles.
6. HRESETn low for 1 cycle during LAUNCH -> all outputs 0 next edge; a subsequent ap_done_i pulse produces no duty_valid_o.
